// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves one branch/jump per handshake and returns a
// single redirect (taken flag plus next PC) to fetch. Conditional branches are
// evaluated by an external comparison unit driven through compSelect/compA/compB,
// with its registered result read back on compResult one cycle later.
// Optional build macro BRANCH_STATS_EN enables the branch/taken statistics counters.
module branch_resolve_unit #(
  parameter int dataWidth   = 32,
  parameter int selectWidth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   brValid,
  output logic                   brReady,
  input  logic                   isJal,
  input  logic                   isJalr,
  input  logic [2:0]             funct3,
  input  logic [dataWidth-1:0]   pc,
  input  logic [dataWidth-1:0]   rs1Val,
  input  logic [dataWidth-1:0]   rs2Val,
  input  logic [dataWidth-1:0]   imm,
  input  logic                   flush,
  output logic [selectWidth-1:0] compSelect,
  output logic [dataWidth-1:0]   compA,
  output logic [dataWidth-1:0]   compB,
  input  logic [dataWidth-1:0]   compResult,
  output logic                   redirectValid,
  input  logic                   redirectReady,
  output logic                   taken,
  output logic                   illegal,
  output logic                   misaligned,
  output logic [dataWidth-1:0]   redirectTarget,
  output logic [dataWidth-1:0]   linkValue,
  output logic [31:0]            branchCount,
  output logic [31:0]            takenCount
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESOLVE} state_t;

  state_t               state_reg;
  logic [dataWidth-1:0] br_target_reg;  // pc+imm, used if the branch is taken
  logic                 cond_reg;       // in-flight instruction is a legal conditional branch

  // Only bit 0 of the comparison result carries the condition.
  logic comp_upper_unused;
  assign comp_upper_unused = |compResult[dataWidth-1:1];

  localparam logic [dataWidth-1:0] FOUR     = dataWidth'(4);
  localparam logic [dataWidth-1:0] LSB_MASK = {{(dataWidth-1){1'b1}}, 1'b0};

  logic [dataWidth-1:0] seq_pc;
  logic [dataWidth-1:0] jal_target;
  logic [dataWidth-1:0] jalr_target;
  logic                 f3_legal;
  logic [selectWidth-1:0] f3_select;

  assign seq_pc      = pc + FOUR;
  assign jal_target  = pc + imm;
  assign jalr_target = (rs1Val + imm) & LSB_MASK;
  assign f3_legal    = (funct3[2:1] != 2'b01);

  // Map the branch funct3 onto the comparison unit's select codes.
  always_comb begin
    f3_select = '0;
    case (funct3)
      3'b000:  f3_select = selectWidth'(0);
      3'b001:  f3_select = selectWidth'(1);
      3'b100:  f3_select = selectWidth'(2);
      3'b101:  f3_select = selectWidth'(5);
      3'b110:  f3_select = selectWidth'(6);
      3'b111:  f3_select = selectWidth'(7);
      default: f3_select = '0;
    endcase
  end

  // A flush in IDLE must block acceptance in the same cycle.
  assign brReady = (state_reg == IDLE) && !flush;

  logic handshake;
  assign handshake = (state_reg == RESOLVE) && redirectReady;

  // Control FSM with all result and comparison-interface outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      br_target_reg  <= '0;
      cond_reg       <= 1'b0;
      compSelect     <= '0;
      compA          <= '0;
      compB          <= '0;
      redirectValid  <= 1'b0;
      taken          <= 1'b0;
      illegal        <= 1'b0;
      misaligned     <= 1'b0;
      redirectTarget <= '0;
      linkValue      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (brValid && !flush) begin
            linkValue     <= seq_pc;
            br_target_reg <= jal_target;
            if (isJalr) begin
              cond_reg       <= 1'b0;
              taken          <= 1'b1;
              illegal        <= 1'b0;
              redirectTarget <= jalr_target;
              misaligned     <= jalr_target[1];
              redirectValid  <= 1'b1;
              state_reg      <= RESOLVE;
            end else if (isJal) begin
              cond_reg       <= 1'b0;
              taken          <= 1'b1;
              illegal        <= 1'b0;
              redirectTarget <= jal_target;
              misaligned     <= jal_target[1];
              redirectValid  <= 1'b1;
              state_reg      <= RESOLVE;
            end else if (!f3_legal) begin
              cond_reg       <= 1'b0;
              taken          <= 1'b0;
              illegal        <= 1'b1;
              redirectTarget <= seq_pc;
              misaligned     <= 1'b0;
              redirectValid  <= 1'b1;
              state_reg      <= RESOLVE;
            end else begin
              cond_reg       <= 1'b1;
              taken          <= 1'b0;
              illegal        <= 1'b0;
              redirectTarget <= seq_pc;
              misaligned     <= 1'b0;
              compSelect     <= f3_select;
              compA          <= rs1Val;
              compB          <= rs2Val;
              state_reg      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Operands are presented for exactly one cycle.
          compSelect <= '0;
          compA      <= '0;
          compB      <= '0;
          state_reg  <= flush ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            taken          <= compResult[0];
            redirectTarget <= compResult[0] ? br_target_reg : linkValue;
            misaligned     <= compResult[0] & br_target_reg[1];
            redirectValid  <= 1'b1;
            state_reg      <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (redirectReady || flush) begin
            redirectValid <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_reg;
  logic [31:0] taken_count_reg;

  // Count completed redirects of legal conditional branches (handshake wins over flush).
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_reg <= '0;
      taken_count_reg  <= '0;
    end else if (handshake && cond_reg) begin
      branch_count_reg <= branch_count_reg + 32'd1;
      if (taken) taken_count_reg <= taken_count_reg + 32'd1;
    end
  end

  assign branchCount = branch_count_reg;
  assign takenCount  = taken_count_reg;
`else
  logic handshake_unused;
  assign handshake_unused = handshake & cond_reg;
  assign branchCount = '0;
  assign takenCount  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit with a registered comparison-unit model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        brValid;
  logic        brReady;
  logic        isJal;
  logic        isJalr;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] rs1Val;
  logic [31:0] rs2Val;
  logic [31:0] imm;
  logic        flush;
  logic [3:0]  compSelect;
  logic [31:0] compA;
  logic [31:0] compB;
  logic [31:0] compResult;
  logic        redirectValid;
  logic        redirectReady;
  logic        taken;
  logic        illegal;
  logic        misaligned;
  logic [31:0] redirectTarget;
  logic [31:0] linkValue;
  logic [31:0] branchCount;
  logic [31:0] takenCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.dataWidth(32), .selectWidth(4)) dut (
    .clk(clk), .reset(reset), .brValid(brValid), .brReady(brReady),
    .isJal(isJal), .isJalr(isJalr), .funct3(funct3), .pc(pc),
    .rs1Val(rs1Val), .rs2Val(rs2Val), .imm(imm), .flush(flush),
    .compSelect(compSelect), .compA(compA), .compB(compB), .compResult(compResult),
    .redirectValid(redirectValid), .redirectReady(redirectReady),
    .taken(taken), .illegal(illegal), .misaligned(misaligned),
    .redirectTarget(redirectTarget), .linkValue(linkValue),
    .branchCount(branchCount), .takenCount(takenCount)
  );

  // Comparison unit: result registered one cycle after operands.
  function automatic logic cmp_eval(logic [3:0] s, logic [31:0] a, logic [31:0] b);
    case (s)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return $signed(a) < $signed(b);
      4'd5:    return $signed(a) >= $signed(b);
      4'd6:    return a < b;
      4'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    compResult <= {31'b0, cmp_eval(compSelect, compA, compB)};
  end

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic drive_req(logic jal, logic jalr, logic [2:0] f3,
                           logic [31:0] p, logic [31:0] a, logic [31:0] b, logic [31:0] im);
    isJal = jal; isJalr = jalr; funct3 = f3;
    pc = p; rs1Val = a; rs2Val = b; imm = im;
    brValid = 1'b1;
    @(negedge clk);
    brValid = 1'b0;
  endtask

  task automatic finish_handshake(string tag);
    redirectReady = 1'b1;
    @(negedge clk);
    redirectReady = 1'b0;
    check_val({tag, "_rv_drop"}, 32'(redirectValid), 32'd0);
    check_val({tag, "_ready_back"}, 32'(brReady), 32'd1);
  endtask

  task automatic run_branch(string tag, logic [2:0] f3, logic [31:0] p, logic [31:0] a,
                            logic [31:0] b, logic [31:0] im, logic [3:0] exp_sel,
                            logic exp_taken, logic [31:0] exp_tgt, logic exp_mis);
    drive_req(1'b0, 1'b0, f3, p, a, b, im);
    check_val({tag, "_issue_sel"}, 32'(compSelect), 32'(exp_sel));
    check_val({tag, "_issue_a"}, compA, a);
    check_val({tag, "_issue_rv"}, 32'(redirectValid), 32'd0);
    @(negedge clk);
    check_val({tag, "_capt_rv"}, 32'(redirectValid), 32'd0);
    check_val({tag, "_capt_sel"}, 32'(compSelect), 32'd0);
    @(negedge clk);
    check_val({tag, "_rv"}, 32'(redirectValid), 32'd1);
    check_val({tag, "_taken"}, 32'(taken), 32'(exp_taken));
    check_val({tag, "_target"}, redirectTarget, exp_tgt);
    check_val({tag, "_link"}, linkValue, p + 32'd4);
    check_val({tag, "_mis"}, 32'(misaligned), 32'(exp_mis));
    check_val({tag, "_ill"}, 32'(illegal), 32'd0);
    finish_handshake(tag);
  endtask

  task automatic run_jump(string tag, logic jal, logic jalr, logic [2:0] f3, logic [31:0] p,
                          logic [31:0] a, logic [31:0] im, logic exp_taken, logic exp_ill,
                          logic [31:0] exp_tgt, logic exp_mis, int hold);
    drive_req(jal, jalr, f3, p, a, 32'h5, im);
    check_val({tag, "_rv"}, 32'(redirectValid), 32'd1);
    check_val({tag, "_sel"}, 32'(compSelect), 32'd0);
    check_val({tag, "_taken"}, 32'(taken), 32'(exp_taken));
    check_val({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
    check_val({tag, "_target"}, redirectTarget, exp_tgt);
    check_val({tag, "_mis"}, 32'(misaligned), 32'(exp_mis));
    check_val({tag, "_link"}, linkValue, p + 32'd4);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_rv"}, 32'(redirectValid), 32'd1);
      check_val({tag, "_hold_target"}, redirectTarget, exp_tgt);
      check_val({tag, "_hold_mis"}, 32'(misaligned), 32'(exp_mis));
    end
    finish_handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; brValid = 1'b0; isJal = 1'b0; isJalr = 1'b0; funct3 = 3'b0;
    pc = '0; rs1Val = '0; rs2Val = '0; imm = '0; flush = 1'b0; redirectReady = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(brReady), 32'd1);
    check_val("rst_rv", 32'(redirectValid), 32'd0);
    check_val("rst_target", redirectTarget, 32'd0);
    check_val("rst_sel", 32'(compSelect), 32'd0);
    check_val("rst_bcnt", branchCount, 32'd0);
    check_val("rst_tcnt", takenCount, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Conditional branches across all legal funct3 codes.
    run_branch("beq",      3'b000, 32'h100, 32'd8, 32'd8, 32'h20, 4'd0, 1'b1, 32'h120, 1'b0);
    run_branch("blt",      3'b100, 32'h200, 32'hFFFFFFF8, 32'd7, 32'h40, 4'd2, 1'b1, 32'h240, 1'b0);
    run_branch("bltu",     3'b110, 32'h200, 32'hFFFFFFF8, 32'd7, 32'h40, 4'd6, 1'b0, 32'h204, 1'b0);
    run_branch("bne",      3'b001, 32'h300, 32'd5, 32'd5, 32'h10, 4'd1, 1'b0, 32'h304, 1'b0);
    run_branch("bge",      3'b101, 32'h400, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFF0, 4'd5, 1'b1, 32'h3F0, 1'b0);
    run_branch("bgeu",     3'b111, 32'h400, 32'd7, 32'hFFFFFFF8, 32'h10, 4'd7, 1'b0, 32'h404, 1'b0);
    run_branch("beq_wrap", 3'b000, 32'hFFFFFFFC, 32'd1, 32'd1, 32'h8, 4'd0, 1'b1, 32'h4, 1'b0);
    run_branch("beq_mis",  3'b000, 32'h100, 32'd3, 32'd3, 32'h22, 4'd0, 1'b1, 32'h122, 1'b1);

    // Jumps and illegal funct3.
    run_jump("jalr",  1'b0, 1'b1, 3'b000, 32'h500, 32'h203, 32'h4, 1'b1, 1'b0, 32'h206, 1'b1, 3);
    run_jump("jal",   1'b1, 1'b0, 3'b000, 32'h600, 32'h0, 32'h100, 1'b1, 1'b0, 32'h700, 1'b0, 0);
    run_jump("ill",   1'b0, 1'b0, 3'b010, 32'h700, 32'h1, 32'h40, 1'b0, 1'b1, 32'h704, 1'b0, 1);
    run_jump("both",  1'b1, 1'b1, 3'b000, 32'h800, 32'h1000, 32'h11, 1'b1, 1'b0, 32'h1010, 1'b0, 0);

    // Flush while in CAPTURE drops the branch.
    drive_req(1'b0, 1'b0, 3'b100, 32'h900, 32'd1, 32'd2, 32'h10);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_val("flush_rv", 32'(redirectValid), 32'd0);
    check_val("flush_ready", 32'(brReady), 32'd1);
    @(negedge clk);
    check_val("flush_rv2", 32'(redirectValid), 32'd0);

    // Flush in IDLE blocks acceptance.
    isJal = 1'b0; isJalr = 1'b0; funct3 = 3'b000; rs1Val = 32'h55; rs2Val = 32'h55;
    pc = 32'hA00; imm = 32'h8;
    flush = 1'b1; brValid = 1'b1;
    #1;
    check_val("idleflush_ready", 32'(brReady), 32'd0);
    @(negedge clk);
    brValid = 1'b0; flush = 1'b0;
    check_val("idleflush_compa", compA, 32'd0);
    check_val("idleflush_rv", 32'(redirectValid), 32'd0);

    // Reset in RESOLVE overrides a simultaneous handshake.
    drive_req(1'b0, 1'b1, 3'b000, 32'h500, 32'h203, 32'h5, 32'h4);
    check_val("rstres_pre_rv", 32'(redirectValid), 32'd1);
    reset = 1'b1; redirectReady = 1'b1;
    @(negedge clk);
    check_val("rstres_rv", 32'(redirectValid), 32'd0);
    check_val("rstres_taken", 32'(taken), 32'd0);
    check_val("rstres_mis", 32'(misaligned), 32'd0);
    check_val("rstres_target", redirectTarget, 32'd0);
    check_val("rstres_link", linkValue, 32'd0);
    check_val("rstres_ready", 32'(brReady), 32'd1);
    reset = 1'b0; redirectReady = 1'b0;
    @(negedge clk);

    // Statistics: 3 taken BNE, 2 not-taken BNE, 1 JAL.
    run_branch("st_t0", 3'b001, 32'h1000, 32'd1, 32'd2, 32'h40, 4'd1, 1'b1, 32'h1040, 1'b0);
    run_branch("st_n0", 3'b001, 32'h1100, 32'd3, 32'd3, 32'h40, 4'd1, 1'b0, 32'h1104, 1'b0);
    run_branch("st_t1", 3'b001, 32'h1200, 32'd4, 32'd0, 32'h80, 4'd1, 1'b1, 32'h1280, 1'b0);
    run_jump("st_jal", 1'b1, 1'b0, 3'b000, 32'h1300, 32'h0, 32'h20, 1'b1, 1'b0, 32'h1320, 1'b0, 0);
    run_branch("st_n1", 3'b001, 32'h1400, 32'd9, 32'd9, 32'h40, 4'd1, 1'b0, 32'h1404, 1'b0);
    run_branch("st_t2", 3'b001, 32'h1500, 32'd9, 32'd8, 32'h10, 4'd1, 1'b1, 32'h1510, 1'b0);
`ifdef BRANCH_STATS_EN
    check_val("stat_bcnt", branchCount, 32'd5);
    check_val("stat_tcnt", takenCount, 32'd3);
`else
    check_val("stat_bcnt", branchCount, 32'd0);
    check_val("stat_tcnt", takenCount, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
